// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial words MSB-first into an external
// comparator. Define SAR_CMP_CHECK_EN to abort on non-one-hot verdicts (err output).
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  output logic             trial_vld,
  input  logic             cmp_vld,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam logic [WIDTH-1:0] MaskMsb = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StTest, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic             trial_vld_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;

  logic             accept;
  logic             bad_verdict;
  logic [WIDTH-1:0] acc_upd;
  logic [WIDTH-1:0] mask_nxt;

  assign accept   = trial_vld_q & cmp_vld;
  // gt clears the trial bit; lt or no flag keeps it.
  assign acc_upd  = cmp_gt ? acc_q : trial_q;
  assign mask_nxt = mask_q >> 1;

`ifdef SAR_CMP_CHECK_EN
  logic err_q;
  assign bad_verdict = !$onehot({cmp_lt, cmp_eq, cmp_gt});
  assign err         = err_q;
`else
  logic unused_lt;
  assign unused_lt   = cmp_lt;
  assign bad_verdict = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mask_q      <= '0;
      trial_q     <= '0;
      result_q    <= '0;
      trial_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
`ifdef SAR_CMP_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StTest;
            acc_q       <= '0;
            mask_q      <= MaskMsb;
            trial_q     <= MaskMsb;
            trial_vld_q <= 1'b1;
            busy_q      <= 1'b1;
            result_q    <= '0;
            found_q     <= 1'b0;
`ifdef SAR_CMP_CHECK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        StTest: begin
          if (accept) begin
            if (bad_verdict || cmp_eq || mask_q[0]) begin
              state_q     <= StDone;
              mask_q      <= '0;
              trial_q     <= '0;
              trial_vld_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              found_q     <= cmp_eq & ~bad_verdict;
              if (bad_verdict) begin
                result_q <= '0;
              end else if (cmp_eq) begin
                result_q <= trial_q;
              end else begin
                result_q <= acc_upd;
              end
`ifdef SAR_CMP_CHECK_EN
              err_q       <= bad_verdict;
`endif
            end else begin
              acc_q   <= acc_upd;
              mask_q  <= mask_nxt;
              trial_q <= acc_upd | mask_nxt;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign trial     = trial_q;
  assign trial_vld = trial_vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign found     = found_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl (WIDTH=3) with a behavioural comparator model.
module tb_sar_search_ctrl;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] trial;
  logic         trial_vld;
  logic         cmp_vld;
  logic         cmp_lt;
  logic         cmp_eq;
  logic         cmp_gt;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         found;
  logic         err;

  typedef struct {
    logic [W-1:0] res;
    logic         fnd;
    logic         er;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] trial_exp_q[$];
  exp_t         mon_e;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           cmp_dly = 0;
  int           wait_cnt = 0;
  logic         force_bad = 1'b0;
  logic [W-1:0] target = '0;

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .trial     (trial),
    .trial_vld (trial_vld),
    .cmp_vld   (cmp_vld),
    .cmp_lt    (cmp_lt),
    .cmp_eq    (cmp_eq),
    .cmp_gt    (cmp_gt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .found     (found),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model; cmp_vld is held off cmp_dly cycles after each new trial.
  always_comb begin
    cmp_lt = (trial < target);
    cmp_eq = (trial == target);
    cmp_gt = (trial > target);
    if (force_bad) begin
      cmp_lt = 1'b1;
      cmp_eq = 1'b0;
      cmp_gt = 1'b1;
    end
    cmp_vld = trial_vld && (wait_cnt >= cmp_dly);
  end

  always @(posedge clk) begin
    if (!trial_vld || cmp_vld) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference search: queues every expected trial word and the final outcome.
  function automatic void push_expect(input int t, input int dly);
    logic [W-1:0] acc;
    logic [W-1:0] tr;
    logic         fnd;
    int           k;
    acc = '0;
    fnd = 1'b0;
    k   = 0;
    for (int b = W - 1; b >= 0; b--) begin
      if (!fnd) begin
        tr = acc | W'(1 << b);
        trial_exp_q.push_back(tr);
        k++;
        if (int'(tr) == t) fnd = 1'b1;
        else if (int'(tr) < t) acc = tr;
      end
    end
    if (fnd) exp_q.push_back(exp_t'{W'(t), 1'b1, 1'b0, k * (dly + 1)});
    else exp_q.push_back(exp_t'{acc, 1'b0, 1'b0, k * (dly + 1)});
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      trial_exp_q.delete();
    end else begin
      if (trial_vld) begin
        check("busy_in_test", busy, 1);
        if (trial_exp_q.size() == 0) check("trial_unexpected", 1, 0);
        else begin
          check("trial", trial, trial_exp_q[0]);
          if (cmp_vld) void'(trial_exp_q.pop_front());
        end
      end else begin
        check("trial_idle_zero", trial, 0);
      end
      if (done) begin
        if (exp_q.size() == 0) check("spurious_done", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("result", result, mon_e.res);
          check("found", found, mon_e.fnd);
          check("err", err, mon_e.er);
          check("latency", cyc - start_cyc, mon_e.lat);
          check("done_busy", busy, 0);
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("done_timeout", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic search(input int t, input int dly, input bit stray);
    cmp_dly = dly;
    target  = W'(t);
    push_expect(t, dly);
    pulse_start();
    if (stray) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_trial", trial, 0);
    check("rst_trial_vld", trial_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_found", found, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    search(5, 0, 1'b0);
    search(0, 0, 1'b0);
    search(4, 0, 1'b0);
    search(7, 0, 1'b0);
    search(3, 2, 1'b1);

    // Reset in the second TEST cycle aborts without done.
    cmp_dly = 0;
    target  = 3'd2;
    push_expect(2, 0);
    pulse_start();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_trial_vld", trial_vld, 0);
    check("abort_trial", trial, 0);
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    repeat (5) @(posedge clk);
    #1;
    search(6, 0, 1'b0);

    // Non-one-hot first verdict (lt and gt both set).
    cmp_dly = 0;
    target  = 3'd2;
`ifdef SAR_CMP_CHECK_EN
    trial_exp_q.push_back(3'b100);
    exp_q.push_back(exp_t'{3'd0, 1'b0, 1'b1, 1});
`else
    push_expect(2, 0);
`endif
    force_bad = 1'b1;
    pulse_start();
    @(posedge clk);
    #1 force_bad = 1'b0;
    wait_drain();

    for (int i = 0; i < 6; i++) search(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
